// File: rtl/pwm_pkg.sv
// rtl/pwm_pkg.sv - shared PWM widths and capture state encoding
package pwm_pkg;

   // Default counter width, shared with the PWM generators so frame widths match.
   localparam int CNT_W_DEF = 11;

   typedef enum logic [1:0] {
      S_WAIT_RISE = 2'd0,
      S_HIGH      = 2'd1,
      S_LOW       = 2'd2,
      S_STUCK     = 2'd3
   } state_t;

endpackage

// File: rtl/pwm_capture_if.sv
// rtl/pwm_capture_if.sv - PWM input pin and measurement result bundle
interface pwm_capture_if #(
   parameter int CNT_W = 11
);
   logic             pwm_in;
   logic [CNT_W-1:0] high_out;
   logic [CNT_W-1:0] period_out;
   logic             valid;
   logic             stuck_hi;
   logic             stuck_lo;
   logic             locked;

   // slave: the capture block; master: whoever drives the pin and consumes results.
   modport slave (
      input  pwm_in,
      output high_out, period_out, valid, stuck_hi, stuck_lo, locked
   );

   modport master (
      output pwm_in,
      input  high_out, period_out, valid, stuck_hi, stuck_lo, locked
   );
endinterface

// File: rtl/pwm_capture_sync_edge.sv
// rtl/pwm_capture_sync_edge.sv - two-flop synchronizer with rise/fall detect
module sync_edge (
   input  logic clk,
   input  logic resetn,
   input  logic async_i,
   output logic rise_o,
   output logic fall_o
);
   logic s1_q;
   logic s2_q;
   logic d_q;

   always_ff @(posedge clk) begin
      if (!resetn) begin
         s1_q <= 1'b0;
         s2_q <= 1'b0;
         d_q  <= 1'b0;
      end else begin
         s1_q <= async_i;
         s2_q <= s1_q;
         d_q  <= s2_q;
      end
   end

   assign rise_o = s2_q & ~d_q;
   assign fall_o = ~s2_q & d_q;
endmodule

// File: rtl/pwm_capture.sv
// rtl/pwm_capture.sv - measures high time and period of an incoming PWM waveform
module pwm_capture
   import pwm_pkg::*;
#(
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic          clk,
   input  logic          resetn,
   pwm_capture_if.slave  bus
);
   localparam logic [CNT_W-1:0] MAX = '1;

   logic             rise;
   logic             fall;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] run_cnt_q, run_cnt_d;
   logic [CNT_W-1:0] hi_lat_q, hi_lat_d;
   logic [CNT_W-1:0] high_q, high_d;
   logic [CNT_W-1:0] period_q, period_d;
   logic             valid_q, valid_d;
   logic             stuck_hi_q, stuck_hi_d;
   logic             stuck_lo_q, stuck_lo_d;
   logic             locked_q, locked_d;

   sync_edge u_sync_edge (
      .clk     (clk),
      .resetn  (resetn),
      .async_i (bus.pwm_in),
      .rise_o  (rise),
      .fall_o  (fall)
   );

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q    <= S_WAIT_RISE;
         run_cnt_q  <= '0;
         hi_lat_q   <= '0;
         high_q     <= '0;
         period_q   <= '0;
         valid_q    <= 1'b0;
         stuck_hi_q <= 1'b0;
         stuck_lo_q <= 1'b0;
         locked_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         run_cnt_q  <= run_cnt_d;
         hi_lat_q   <= hi_lat_d;
         high_q     <= high_d;
         period_q   <= period_d;
         valid_q    <= valid_d;
         stuck_hi_q <= stuck_hi_d;
         stuck_lo_q <= stuck_lo_d;
         locked_q   <= locked_d;
      end
   end

   // Edges are tested before the MAX timeout so a period of exactly MAX still measures.
   always_comb begin
      state_d    = state_q;
      hi_lat_d   = hi_lat_q;
      high_d     = high_q;
      period_d   = period_q;
      valid_d    = 1'b0;
      stuck_hi_d = stuck_hi_q;
      stuck_lo_d = stuck_lo_q;
      locked_d   = locked_q;

      if (rise)
         run_cnt_d = CNT_W'(1);
      else if (run_cnt_q == MAX)
         run_cnt_d = run_cnt_q;
      else
         run_cnt_d = run_cnt_q + CNT_W'(1);

      case (state_q)
         S_WAIT_RISE: begin
            if (rise)
               state_d = S_HIGH;
         end
         S_HIGH: begin
            if (fall) begin
               hi_lat_d = run_cnt_q;
               state_d  = S_LOW;
            end else if (run_cnt_q == MAX) begin
               stuck_hi_d = 1'b1;
               locked_d   = 1'b0;
               valid_d    = 1'b1;
               high_d     = MAX;
               period_d   = MAX;
               state_d    = S_STUCK;
            end
         end
         S_LOW: begin
            if (rise) begin
               high_d     = hi_lat_q;
               period_d   = run_cnt_q;
               valid_d    = 1'b1;
               locked_d   = 1'b1;
               stuck_hi_d = 1'b0;
               stuck_lo_d = 1'b0;
               state_d    = S_HIGH;
            end else if (run_cnt_q == MAX) begin
               stuck_lo_d = 1'b1;
               locked_d   = 1'b0;
               valid_d    = 1'b1;
               high_d     = '0;
               period_d   = MAX;
               state_d    = S_STUCK;
            end
         end
         S_STUCK: begin
            if (rise)
               state_d = S_HIGH;
         end
         default: state_d = S_WAIT_RISE;
      endcase
   end

   assign bus.high_out   = high_q;
   assign bus.period_out = period_q;
   assign bus.valid      = valid_q;
   assign bus.stuck_hi   = stuck_hi_q;
   assign bus.stuck_lo   = stuck_lo_q;
   assign bus.locked     = locked_q;
endmodule

// File: tb/tb_pwm_capture.sv
// tb/tb_pwm_capture.sv - scoreboard bench for pwm_capture
module tb_pwm_capture;
   localparam int W   = 11;
   localparam int MAX = 2047;

   typedef struct {
      int   high;
      int   period;
      logic shi;
      logic slo;
      logic lck;
   } exp_t;

   typedef struct {
      int h;
      int l;
      int n;
      int exp_high;
      int exp_period;
   } vec_t;

   logic clk = 1'b0;
   logic resetn = 1'b0;
   int   total = 0;
   int   bad = 0;
   int   cyc = 0;
   logic prev_valid = 1'b0;
   exp_t sb[$];
   int   valid_cycs[$];
   vec_t vecs[4];

   pwm_capture_if #(.CNT_W(W)) bus ();

   pwm_capture #(.CNT_W(W)) dut (
      .clk    (clk),
      .resetn (resetn),
      .bus    (bus)
   );

   always #5 clk = ~clk;

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   initial begin
      #3_000_000;
      $display("FAIL watchdog: run did not finish, total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic drive(input logic lvl, input int n);
      bus.pwm_in = lvl;
      repeat (n) @(negedge clk);
   endtask

   task automatic push(input int h, input int p, input logic shi, input logic slo, input logic lck);
      exp_t e;
      e.high = h; e.period = p; e.shi = shi; e.slo = slo; e.lck = lck;
      sb.push_back(e);
   endtask

   // Every pushed frame must be followed by a rise, which completes its measurement.
   task automatic frame(input int h, input int l);
      push(h, h + l, 1'b0, 1'b0, 1'b1);
      drive(1'b1, h);
      drive(1'b0, l);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_high"},   int'(bus.high_out),   0);
      check({tag, "_period"}, int'(bus.period_out), 0);
      check({tag, "_valid"},  int'(bus.valid),      0);
      check({tag, "_shi"},    int'(bus.stuck_hi),   0);
      check({tag, "_slo"},    int'(bus.stuck_lo),   0);
      check({tag, "_locked"}, int'(bus.locked),     0);
   endtask

   initial forever begin
      exp_t e;
      @(negedge clk);
      if (resetn && bus.valid) begin
         check("valid_not_back_to_back", int'(prev_valid), 0);
         valid_cycs.push_back(cyc);
         if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_valid: got high=%0d period=%0d expected no valid (cycle %0d)",
                     bus.high_out, bus.period_out, cyc);
         end else begin
            e = sb.pop_front();
            check("high_out",   int'(bus.high_out),   e.high);
            check("period_out", int'(bus.period_out), e.period);
            check("stuck_hi",   int'(bus.stuck_hi),   int'(e.shi));
            check("stuck_lo",   int'(bus.stuck_lo),   int'(e.slo));
            check("locked",     int'(bus.locked),     int'(e.lck));
         end
      end
      prev_valid = bus.valid;
   end

   initial begin
      vecs[0] = '{h: 3,    l: 5, n: 4, exp_high: 3,    exp_period: 8};
      vecs[1] = '{h: 6,    l: 2, n: 3, exp_high: 6,    exp_period: 8};
      vecs[2] = '{h: 1,    l: 1, n: 6, exp_high: 1,    exp_period: 2};
      vecs[3] = '{h: 2046, l: 1, n: 1, exp_high: 2046, exp_period: 2047};

      bus.pwm_in = 1'b0;
      resetn = 1'b0;
      repeat (8) @(negedge clk);
      check_all_zero("reset");
      resetn = 1'b1;
      drive(1'b0, 4);

      foreach (vecs[i]) begin
         for (int k = 0; k < vecs[i].n; k++) begin
            push(vecs[i].exp_high, vecs[i].exp_period, 1'b0, 1'b0, 1'b1);
            drive(1'b1, vecs[i].h);
            drive(1'b0, vecs[i].l);
         end
      end

      // Stuck high: the rise closes the 2046/1 frame, then times out MAX cycles later.
      push(MAX, MAX, 1'b1, 1'b0, 1'b0);
      drive(1'b1, 3000);
      if (valid_cycs.size() >= 2)
         check("stuck_hi_delay", valid_cycs[valid_cycs.size()-1] - valid_cycs[valid_cycs.size()-2], MAX);
      else
         check("stuck_hi_valid_count", valid_cycs.size(), 2);
      drive(1'b0, 10);
      check("stuck_hi_held", int'(bus.stuck_hi), 1);
      check("stuck_hi_unlocked", int'(bus.locked), 0);
      frame(10, 10);
      check("stuck_hi_held_first_rise", int'(bus.stuck_hi), 1);
      frame(10, 10);
      frame(10, 10);

      // Stuck low: a high pulse closes the last frame, then the line idles low.
      push(0, MAX, 1'b0, 1'b1, 1'b0);
      drive(1'b1, 10);
      drive(1'b0, 3000);
      check("stuck_lo_held", int'(bus.stuck_lo), 1);
      frame(4, 4);
      check("stuck_lo_held_first_rise", int'(bus.stuck_lo), 1);
      frame(4, 4);
      frame(4, 4);

      // Reset while high: the in-progress frame is discarded.
      drive(1'b1, 5);
      resetn = 1'b0;
      bus.pwm_in = 1'b0;
      @(negedge clk);
      check_all_zero("midreset");
      @(negedge clk);
      resetn = 1'b1;
      drive(1'b0, 5);
      frame(5, 7);
      frame(5, 7);
      frame(5, 7);
      drive(1'b1, 10);

      check("scoreboard_drained", sb.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
